// File: rtl/wvb_dpram_streamer.sv
// rtl/wvb_dpram_streamer.sv - drains filled DPRAM pages as a 16-bit valid/ready halfword stream
module wvb_dpram_streamer #(
    parameter int P_DPRAM_ADR_WIDTH = 10,
    parameter int P_RD_LAT          = 2,
    parameter int P_PF_DEPTH        = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         en,
    input  logic                         dpram_run,
    input  logic [15:0]                  dpram_len,
    output logic                         dpram_busy,
    output logic [P_DPRAM_ADR_WIDTH-1:0] dpram_rd_addr,
    output logic                         dpram_rd_en,
    input  logic [31:0]                  dpram_rd_data,
    output logic [15:0]                  out_data,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic                         out_last,
    output logic                         len_err,
    output logic [15:0]                  pages_done
);
    localparam int LW  = P_DPRAM_ADR_WIDTH + 1;
    localparam int PW  = $clog2(P_PF_DEPTH);
    localparam int CW  = PW + 1;
    localparam int CAP = 2 ** P_DPRAM_ADR_WIDTH;
    localparam logic [16:0]   CAP17   = CAP[16:0];
    localparam logic [LW-1:0] CAP_LW  = CAP[LW-1:0];
    localparam logic [CW:0]   DEPTH_S = P_PF_DEPTH[CW:0];

    typedef enum logic [1:0] {S_IDLE, S_XFER, S_DONE} state_t;

    state_t                state_q, state_d;
    logic [LW-1:0]         len_q, len_d;
    logic [LW-1:0]         rd_cnt_q, rd_cnt_d;
    logic [LW-1:0]         wd_cnt_q, wd_cnt_d;
    logic                  busy_q, busy_d;
    logic                  len_err_q, len_err_d;
    logic [15:0]           pages_q, pages_d;
    logic                  sel_q, sel_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [CW-1:0]         infl_q, infl_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [P_RD_LAT-1:0]   sr_q, sr_d;
    logic [31:0]           fifo_mem_q [P_PF_DEPTH];

    logic        rd_en, push, pop, accept, last_acc, credit_ok, valid, last;
    logic [31:0] head;
    logic [CW:0] credit_sum;

    // Read issue, FIFO push/pop and halfword presentation
    always_comb begin
        credit_sum = {1'b0, cnt_q} + {1'b0, infl_q};
        credit_ok  = credit_sum < DEPTH_S;
        rd_en      = en && (state_q == S_XFER) && (rd_cnt_q < len_q) && credit_ok;
        push       = en && sr_q[P_RD_LAT-1];
        head       = fifo_mem_q[rd_ptr_q];
        valid      = (state_q == S_XFER) && (cnt_q != '0);
        last       = valid && sel_q && (wd_cnt_q == len_q - LW'(1));
        accept     = valid && out_ready;
        pop        = accept && sel_q;
        last_acc   = accept && last;
    end

    assign dpram_rd_en   = rd_en;
    assign dpram_rd_addr = rd_en ? rd_cnt_q[P_DPRAM_ADR_WIDTH-1:0] : '0;
    assign out_valid     = valid;
    assign out_last      = last;
    assign out_data      = !valid ? 16'h0 : (sel_q ? head[15:0] : head[31:16]);
    assign dpram_busy    = busy_q;
    assign len_err       = len_err_q;
    assign pages_done    = pages_q;

    // Next-state: page FSM, counters, prefetch bookkeeping, synchronous abort
    always_comb begin
        state_d   = state_q;
        len_d     = len_q;
        rd_cnt_d  = rd_cnt_q;
        wd_cnt_d  = wd_cnt_q;
        busy_d    = busy_q;
        len_err_d = len_err_q;
        pages_d   = pages_q;
        sel_d     = sel_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        sr_d      = (sr_q << 1) | P_RD_LAT'(rd_en);
        infl_d    = infl_q + CW'(rd_en) - CW'(push);
        cnt_d     = cnt_q + CW'(push) - CW'(pop);
        if (rd_en) rd_cnt_d = rd_cnt_q + LW'(1);
        if (push)  wr_ptr_d = wr_ptr_q + PW'(1);
        if (accept) sel_d = ~sel_q;
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
            wd_cnt_d = wd_cnt_q + LW'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (dpram_run) begin
                    busy_d   = 1'b1;
                    rd_cnt_d = '0;
                    wd_cnt_d = '0;
                    if ({1'b0, dpram_len} > CAP17) begin
                        len_d     = CAP_LW;
                        len_err_d = 1'b1;
                    end else begin
                        len_d = dpram_len[LW-1:0];
                    end
                    state_d = (dpram_len == 16'h0) ? S_DONE : S_XFER;
                end
            end
            S_XFER: begin
                if (last_acc) begin
                    busy_d  = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                pages_d = pages_q + 16'd1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
        if (!en) begin
            state_d   = S_IDLE;
            len_d     = '0;
            rd_cnt_d  = '0;
            wd_cnt_d  = '0;
            busy_d    = 1'b0;
            sel_d     = 1'b0;
            cnt_d     = '0;
            infl_d    = '0;
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            sr_d      = '0;
            len_err_d = len_err_q;
            pages_d   = pages_q;
        end
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            len_q     <= '0;
            rd_cnt_q  <= '0;
            wd_cnt_q  <= '0;
            busy_q    <= 1'b0;
            len_err_q <= 1'b0;
            pages_q   <= '0;
            sel_q     <= 1'b0;
            cnt_q     <= '0;
            infl_q    <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            sr_q      <= '0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            rd_cnt_q  <= rd_cnt_d;
            wd_cnt_q  <= wd_cnt_d;
            busy_q    <= busy_d;
            len_err_q <= len_err_d;
            pages_q   <= pages_d;
            sel_q     <= sel_d;
            cnt_q     <= cnt_d;
            infl_q    <= infl_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            sr_q      <= sr_d;
        end
    end

    // Prefetch FIFO storage; occupancy is tracked by the pointers and count above
    always_ff @(posedge clk) begin
        if (push) fifo_mem_q[wr_ptr_q] <= dpram_rd_data;
    end
endmodule

// File: tb/tb_wvb_dpram_streamer.sv
// tb/tb_wvb_dpram_streamer.sv - randomized self-checking bench for wvb_dpram_streamer
module tb_wvb_dpram_streamer;
    localparam int AW     = 10;
    localparam int RD_LAT = 2;
    localparam int DEPTH  = 4;

    logic          clk = 1'b0;
    logic          rst_n, en, dpram_run, out_ready;
    logic [15:0]   dpram_len;
    logic          dpram_busy, dpram_rd_en, out_valid, out_last, len_err;
    logic [AW-1:0] dpram_rd_addr;
    logic [31:0]   dpram_rd_data;
    logic [15:0]   out_data, pages_done;

    int errors = 0;
    int checks = 0;

    wvb_dpram_streamer #(.P_DPRAM_ADR_WIDTH(AW), .P_RD_LAT(RD_LAT), .P_PF_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .dpram_run(dpram_run), .dpram_len(dpram_len),
        .dpram_busy(dpram_busy), .dpram_rd_addr(dpram_rd_addr), .dpram_rd_en(dpram_rd_en),
        .dpram_rd_data(dpram_rd_data), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_last(out_last), .len_err(len_err), .pages_done(pages_done)
    );

    always #5 clk = ~clk;

    // DPRAM model: data for an address appears RD_LAT cycles after it was presented
    logic [31:0]   mem [0:(1<<AW)-1];
    logic [AW-1:0] ap  [RD_LAT];
    always @(posedge clk) begin
        ap[0] <= dpram_rd_addr;
        for (int i = 1; i < RD_LAT; i++) ap[i] <= ap[i-1];
    end
    assign dpram_rd_data = mem[ap[RD_LAT-1]];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor sampled on the falling edge
    logic        mon_clr = 1'b0;
    logic [16:0] q_hw[$];
    int          q_cyc[$];
    int busy_rise, busy_fall, first_valid, busy_cycles, valid_seen;
    int issued, popped, accepts, max_out, max_addr, first_addr, stab_viol;
    logic p_busy, p_valid, p_ready, p_en, p_last;
    logic [15:0] p_data;
    always @(negedge clk) begin
        if (mon_clr) begin
            q_hw.delete(); q_cyc.delete();
            busy_rise = -1; busy_fall = -1; first_valid = -1; busy_cycles = 0; valid_seen = 0;
            issued = 0; popped = 0; accepts = 0; max_out = 0; max_addr = -1; first_addr = -1;
            stab_viol = 0;
        end else begin
            if (en && p_en && p_valid && !p_ready &&
                !(out_valid && out_data === p_data && out_last === p_last))
                stab_viol++;
            if (dpram_busy && !p_busy) busy_rise = cyc;
            if (!dpram_busy && p_busy) busy_fall = cyc;
            if (dpram_busy) busy_cycles++;
            if (out_valid) begin
                valid_seen++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (dpram_rd_en) begin
                issued++;
                if (first_addr < 0) first_addr = int'(dpram_rd_addr);
                if (int'(dpram_rd_addr) > max_addr) max_addr = int'(dpram_rd_addr);
            end
            if (issued - popped > max_out) max_out = issued - popped;
            if (out_valid && out_ready) begin
                q_hw.push_back({out_last, out_data});
                q_cyc.push_back(cyc);
                accepts++;
                if (accepts % 2 == 0) popped++;
            end
        end
        p_busy = dpram_busy; p_valid = out_valid; p_ready = out_ready; p_en = en;
        p_data = out_data; p_last = out_last;
    end

    task automatic clear_mon();
        mon_clr = 1'b1;
        @(negedge clk);
        #1 mon_clr = 1'b0;
    endtask

    task automatic fill_mem();
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
    endtask

    task automatic start_page(input int len);
        @(posedge clk);
        #1 dpram_len = 16'(len); dpram_run = 1'b1;
        @(posedge clk);
        #1 dpram_run = 1'b0;
    endtask

    // Drives out_ready (random when rnd) until dpram_busy falls or the budget expires
    task automatic wait_page(input string name, input int budget, input bit rnd);
        int n = 0;
        while (busy_fall < 0 && n < budget) begin
            @(posedge clk);
            #1 if (rnd) out_ready = 1'($urandom_range(0, 1));
            n++;
        end
        out_ready = 1'b1;
        checks++;
        if (busy_fall < 0) begin
            errors++;
            $display("FAIL %s timeout: busy still %0b after %0d cycles, required fall", name, dpram_busy, budget);
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    // Reference: page of len words streams hi then lo of each word, last on final lo
    function automatic int stream_mismatches(input int len);
        int n   = (len > (1 << AW)) ? (1 << AW) : len;
        int bad = (q_hw.size() != 2 * n) ? 1 : 0;
        logic [16:0] e;
        for (int i = 0; i < 2 * n && i < q_hw.size(); i++) begin
            e = (i % 2 == 0) ? {1'b0, mem[i/2][31:16]} : {(i == 2*n - 1), mem[i/2][15:0]};
            if (q_hw[i] !== e) bad++;
        end
        return bad;
    endfunction

    task automatic test_reset();
        logic [AW+51:0] outs;
        rst_n = 1'b0; en = 1'b1; dpram_run = 1'b0; dpram_len = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 outs = {dpram_busy, dpram_rd_en, dpram_rd_addr, out_valid, out_data, out_last, len_err, pages_done};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_outputs: got %h required 0", outs); end
        rst_n = 1'b1;
        fill_mem();
        clear_mon();
        out_ready = 1'b1;
        start_page(10);
        repeat (6) @(posedge clk);
        #3 rst_n = 1'b0;
        #1 outs = {dpram_busy, dpram_rd_en, dpram_rd_addr, out_valid, out_data, out_last, len_err, pages_done};
        checks++;
        if (outs !== '0) begin errors++; $display("FAIL reset_midxfer: got %h required 0", outs); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({dpram_busy, out_valid, pages_done} !== '0) begin
            errors++;
            $display("FAIL reset_release: busy=%0b valid=%0b pages=%0d required 0", dpram_busy, out_valid, pages_done);
        end
    endtask

    task automatic test_basic();
        int m;
        mem[0] = 32'hAAAA1111; mem[1] = 32'hBBBB2222; mem[2] = 32'hCCCC3333;
        out_ready = 1'b1;
        clear_mon();
        start_page(3);
        wait_page("basic", 100, 1'b0);
        m = stream_mismatches(3);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL basic_stream: %0d bad of %0d halfwords, required 0 bad of 6", m, q_hw.size()); end
        if (q_cyc.size() == 6) begin
            checks++;
            if (q_cyc[5] - q_cyc[0] !== 5) begin errors++; $display("FAIL basic_consecutive: span %0d required 5", q_cyc[5] - q_cyc[0]); end
            checks++;
            if (busy_fall !== q_cyc[5] + 1) begin errors++; $display("FAIL basic_busy_fall: cycle %0d required %0d", busy_fall, q_cyc[5] + 1); end
        end
        checks++;
        if (first_valid - busy_rise !== RD_LAT + 1) begin
            errors++; $display("FAIL basic_latency: %0d required %0d", first_valid - busy_rise, RD_LAT + 1);
        end
        checks++;
        if (pages_done !== 16'd1) begin errors++; $display("FAIL basic_pages: %0d required 1", pages_done); end
    endtask

    task automatic test_backpressure();
        int m;
        int lens[3] = '{16, 1, 0};
        int exp_pages = int'(pages_done);
        lens[1] = $urandom_range(2, 40);
        lens[2] = $urandom_range(2, 40);
        for (int k = 0; k < 3; k++) begin
            fill_mem();
            clear_mon();
            start_page(lens[k]);
            wait_page("backpressure", 2000, 1'b1);
            exp_pages++;
            m = stream_mismatches(lens[k]);
            checks++;
            if (m !== 0) begin errors++; $display("FAIL bp_stream len=%0d: %0d bad, got %0d halfwords required %0d", lens[k], m, q_hw.size(), 2*lens[k]); end
            checks++;
            if (max_out > DEPTH) begin errors++; $display("FAIL bp_fifo_occupancy: %0d required <= %0d", max_out, DEPTH); end
            checks++;
            if (max_addr !== lens[k] - 1) begin errors++; $display("FAIL bp_max_addr: %0d required %0d", max_addr, lens[k] - 1); end
            checks++;
            if (stab_viol !== 0) begin errors++; $display("FAIL bp_stability: %0d violations required 0", stab_viol); end
            checks++;
            if (int'(pages_done) !== exp_pages) begin errors++; $display("FAIL bp_pages: %0d required %0d", pages_done, exp_pages); end
        end
    endtask

    task automatic test_zero_len();
        int exp_pages = int'(pages_done) + 1;
        clear_mon();
        start_page(0);
        wait_page("zero_len", 20, 1'b0);
        checks++;
        if (busy_cycles !== 1) begin errors++; $display("FAIL zero_busy_cycles: %0d required 1", busy_cycles); end
        checks++;
        if (valid_seen !== 0) begin errors++; $display("FAIL zero_valid: %0d cycles required 0", valid_seen); end
        checks++;
        if (int'(pages_done) !== exp_pages) begin errors++; $display("FAIL zero_pages: %0d required %0d", pages_done, exp_pages); end
    endtask

    task automatic test_overlength();
        int m;
        int exp_pages = int'(pages_done) + 1;
        fill_mem();
        clear_mon();
        start_page(1024);
        wait_page("exact_cap", 3000, 1'b0);
        m = stream_mismatches(1024);
        checks++;
        if (m !== 0 || len_err !== 1'b0) begin errors++; $display("FAIL cap_stream: %0d bad len_err=%0b required 0 bad len_err=0", m, len_err); end
        exp_pages++;
        fill_mem();
        clear_mon();
        start_page(1500);
        repeat (100) @(posedge clk);
        #1 dpram_len = 16'd5; dpram_run = 1'b1;
        @(posedge clk);
        #1 dpram_run = 1'b0;
        wait_page("overlength", 3000, 1'b0);
        repeat (5) @(posedge clk);
        #1 m = stream_mismatches(1500);
        checks++;
        if (m !== 0) begin errors++; $display("FAIL over_stream: %0d bad, got %0d halfwords required 2048", m, q_hw.size()); end
        checks++;
        if (len_err !== 1'b1) begin errors++; $display("FAIL over_len_err: %0b required 1", len_err); end
        checks++;
        if (max_addr !== 1023) begin errors++; $display("FAIL over_max_addr: %0d required 1023", max_addr); end
        checks++;
        if (int'(pages_done) !== exp_pages || dpram_busy !== 1'b0) begin
            errors++; $display("FAIL over_ignored_run: pages=%0d busy=%0b required %0d and 0", pages_done, dpram_busy, exp_pages);
        end
    endtask

    task automatic test_abort();
        int m, n;
        int exp_pages = int'(pages_done);
        fill_mem();
        clear_mon();
        out_ready = 1'b1;
        start_page(10);
        n = 0;
        while (q_hw.size() < 5 && n < 100) begin
            @(posedge clk);
            #1 n++;
        end
        en = 1'b0; out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || dpram_busy !== 1'b0) begin
            errors++; $display("FAIL abort_clear: valid=%0b busy=%0b required 0 0", out_valid, dpram_busy);
        end
        checks++;
        if (q_hw.size() !== 5 || q_hw[4][16] !== 1'b0) begin
            errors++; $display("FAIL abort_partial: %0d halfwords required 5 without last", q_hw.size());
        end
        repeat (3) @(posedge clk);
        #1 en = 1'b1; out_ready = 1'b1;
        checks++;
        if (int'(pages_done) !== exp_pages) begin errors++; $display("FAIL abort_pages: %0d required %0d", pages_done, exp_pages); end
        fill_mem();
        clear_mon();
        start_page(4);
        wait_page("after_abort", 200, 1'b0);
        m = stream_mismatches(4);
        checks++;
        if (m !== 0 || first_addr !== 0) begin
            errors++; $display("FAIL abort_next_page: %0d bad first_addr=%0d required 0 bad addr 0", m, first_addr);
        end
        checks++;
        if (int'(pages_done) !== exp_pages + 1) begin errors++; $display("FAIL abort_next_pages: %0d required %0d", pages_done, exp_pages + 1); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_len();
        test_overlength();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
